// File: rtl/veggie_motion.sv
// -----------------------------------------------------------------------------
// veggie_motion
//
// Per-frame motion engine for one thrown veggie. Integrates a ballistic
// trajectory once per video frame, forks into two independently moving halves
// when sliced, and flags the veggie gone once it has left the screen.
// Feeds the top/bottom split_sprite instances.
//
// Ports
//   pixel_clk_in     in   pixel clock, all logic on the rising edge
//   rst_n_in         in   asynchronous active-low reset
//   new_frame_in     in   one-cycle pulse at the start of each frame
//   launch_in        in   one-cycle pulse: start a throw (honoured in IDLE only)
//   launch_x_in      in   [10:0] initial centre x
//   launch_y_in      in   [9:0]  initial centre y
//   launch_vx_in     in   [5:0]  initial vx, two's complement
//   launch_vy_in     in   [7:0]  initial vy, two's complement, negative = up
//   slice_in         in   one-cycle pulse: blade crossed veggie (FLY only)
//   slice_angle_in   in   [9:0]  blade angle, latched on an accepted slice
//   x_top_out        out  [10:0] top-half (or whole veggie) centre x
//   y_top_out        out  [9:0]  top-half (or whole veggie) centre y
//   x_bot_out        out  [10:0] bottom-half centre x
//   y_bot_out        out  [9:0]  bottom-half centre y
//   split_out        out  high from accepted slice until back in IDLE
//   angle_out        out  [9:0]  latched slice angle
//   veggie_gone_out  out  high in IDLE and GONE
//   state_dbg_out    out  [1:0]  current FSM state (IDLE=0 FLY=1 SPLIT=2 GONE=3)
//
// Handshake: there is no backpressure. new_frame_in, launch_in and slice_in
// are single-cycle strobes, sampled on the rising edge they are high for;
// strobes arriving in a state that does not accept them are dropped.
// -----------------------------------------------------------------------------
module veggie_motion #(
  parameter int SCREEN_W   = 1024,
  parameter int SCREEN_H   = 768,
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int GRAVITY    = 1,
  parameter int SPLIT_DX   = 2,
  parameter int SPLIT_KICK = 3
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        new_frame_in,
  input  logic        launch_in,
  input  logic [10:0] launch_x_in,
  input  logic [9:0]  launch_y_in,
  input  logic [5:0]  launch_vx_in,
  input  logic [7:0]  launch_vy_in,
  input  logic        slice_in,
  input  logic [9:0]  slice_angle_in,
  output logic [10:0] x_top_out,
  output logic [9:0]  y_top_out,
  output logic [10:0] x_bot_out,
  output logic [9:0]  y_bot_out,
  output logic        split_out,
  output logic [9:0]  angle_out,
  output logic        veggie_gone_out,
  output logic [1:0]  state_dbg_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    SPLIT = 2'd2,
    GONE  = 2'd3
  } state_t;

  // Off-screen bounds: a half is out once its centre is half a sprite past
  // the bottom, left or right edge. Leaving through the top is not an exit.
  localparam logic signed [12:0] Y_LIM = 13'(SCREEN_H + HEIGHT / 2);
  localparam logic signed [12:0] X_LO  = 13'(-(WIDTH / 2));
  localparam logic signed [12:0] X_HI  = 13'(SCREEN_W + WIDTH / 2);

  localparam logic signed [7:0] GRAV  = 8'(GRAVITY);
  localparam logic signed [7:0] P_DX  = 8'(SPLIT_DX);
  localparam logic signed [7:0] N_DX  = 8'(-SPLIT_DX);
  localparam logic signed [7:0] N_KCK = 8'(-SPLIT_KICK);

  state_t state;

  logic signed [12:0] xt, yt, xb, yb;
  logic signed [7:0]  vxt, vyt, vxb, vyb;

  // Candidate post-frame values for both halves.
  logic signed [12:0] xt_n, yt_n, xb_n, yb_n;
  logic signed [7:0]  vyt_n, vyb_n;
  logic               out_t, out_b;

  // Saturating 8-bit signed add.
  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                 input logic signed [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)       return 8'sd127;
    else if (s < -9'sd128) return -8'sd128;
    else                   return s[7:0];
  endfunction

  function automatic logic signed [12:0] sext_v(input logic signed [7:0] v);
    return $signed({{5{v[7]}}, v});
  endfunction

  // Clamp internal positions into the unsigned port ranges.
  function automatic logic [10:0] sat_x(input logic signed [12:0] v);
    if (v < 13'sd0)         return 11'd0;
    else if (v > 13'sd2047) return 11'd2047;
    else                    return v[10:0];
  endfunction

  function automatic logic [9:0] sat_y(input logic signed [12:0] v);
    if (v < 13'sd0)         return 10'd0;
    else if (v > 13'sd1023) return 10'd1023;
    else                    return v[9:0];
  endfunction

  function automatic logic is_out(input logic signed [12:0] x,
                                  input logic signed [12:0] y);
    return (y >= Y_LIM) || (x < X_LO) || (x >= X_HI);
  endfunction

  // Position moves by the velocity held before this frame's gravity step.
  always_comb begin
    xt_n  = xt + sext_v(vxt);
    yt_n  = yt + sext_v(vyt);
    xb_n  = xb + sext_v(vxb);
    yb_n  = yb + sext_v(vyb);
    vyt_n = sat_add8(vyt, GRAV);
    vyb_n = sat_add8(vyb, GRAV);
    out_t = is_out(xt_n, yt_n);
    out_b = is_out(xb_n, yb_n);
  end

  assign state_dbg_out = state;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      xt              <= '0;
      yt              <= '0;
      xb              <= '0;
      yb              <= '0;
      vxt             <= '0;
      vyt             <= '0;
      vxb             <= '0;
      vyb             <= '0;
      x_top_out       <= '0;
      y_top_out       <= '0;
      x_bot_out       <= '0;
      y_bot_out       <= '0;
      split_out       <= 1'b0;
      angle_out       <= '0;
      veggie_gone_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A launch coinciding with new_frame_in only loads; motion starts
          // on the following frame.
          if (launch_in) begin
            xt              <= {2'b00, launch_x_in};
            xb              <= {2'b00, launch_x_in};
            yt              <= {3'b000, launch_y_in};
            yb              <= {3'b000, launch_y_in};
            vxt             <= {{2{launch_vx_in[5]}}, launch_vx_in};
            vxb             <= {{2{launch_vx_in[5]}}, launch_vx_in};
            vyt             <= launch_vy_in;
            vyb             <= launch_vy_in;
            x_top_out       <= launch_x_in;
            x_bot_out       <= launch_x_in;
            y_top_out       <= launch_y_in;
            y_bot_out       <= launch_y_in;
            veggie_gone_out <= 1'b0;
            state           <= FLY;
          end
        end

        FLY: begin
          // Slice wins over a coincident frame: velocities fork, positions
          // hold for this frame.
          if (slice_in) begin
            split_out <= 1'b1;
            angle_out <= slice_angle_in;
            vxt       <= sat_add8(vxt, P_DX);
            vxb       <= sat_add8(vxb, N_DX);
            vyt       <= sat_add8(vyt, N_KCK);
            state     <= SPLIT;
          end else if (new_frame_in) begin
            xt        <= xt_n;
            yt        <= yt_n;
            xb        <= xb_n;
            yb        <= yb_n;
            vyt       <= vyt_n;
            vyb       <= vyb_n;
            x_top_out <= sat_x(xt_n);
            y_top_out <= sat_y(yt_n);
            x_bot_out <= sat_x(xb_n);
            y_bot_out <= sat_y(yb_n);
            // Halves are identical before a split, so one test suffices.
            if (out_t) begin
              veggie_gone_out <= 1'b1;
              state           <= GONE;
            end
          end
        end

        SPLIT: begin
          if (new_frame_in) begin
            xt        <= xt_n;
            yt        <= yt_n;
            xb        <= xb_n;
            yb        <= yb_n;
            vyt       <= vyt_n;
            vyb       <= vyb_n;
            x_top_out <= sat_x(xt_n);
            y_top_out <= sat_y(yt_n);
            x_bot_out <= sat_x(xb_n);
            y_bot_out <= sat_y(yb_n);
            if (out_t && out_b) begin
              veggie_gone_out <= 1'b1;
              state           <= GONE;
            end
          end
        end

        GONE: begin
          // Positions and angle stay frozen; only split clears on the way out.
          if (new_frame_in) begin
            split_out <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
